present_bus_sequencer: RTL and testbench

Upstream master for the PRESENT register-mapped wrapper. Accepts one 64-bit block, 80-bit key and direction over a valid/ready stream. It runs the wrapper's chip-select/write/read register protocol to load operands, trigger a PRESENT encrypt or decrypt, wait a fixed latency, and read back the 64-bit result. It returns the result on a valid/ready output stream. It skips re-writing the key when the key and direction match the last operation.

---
 rtl/present_bus_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_present_bus_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_bus_sequencer.sv
// Upstream master for the PRESENT register-mapped wrapper: programs key/data/control,
// pulses load, waits a fixed latency, reads back the result and streams it out.
module present_bus_sequencer #(
    parameter int WAIT_CYCLES = 80
) (
    input  logic        clk,
    input  logic        iReset,
    input  logic        iValid,
    output logic        oReady,
    input  logic [63:0] iData,
    input  logic [79:0] iKey,
    input  logic        iDecrypt,
    output logic        oValid,
    input  logic        iReady,
    output logic [63:0] oData,
    output logic        oChipselect_n,
    output logic        oWrite_n,
    output logic        oRead_n,
    output logic [3:0]  oAddress,
    output logic [31:0] oWdat,
    input  logic [31:0] iRdat
);

    typedef enum logic [3:0] {
        S_IDLE, S_WKEY3, S_WKEY2, S_WKEY1, S_WDAT5, S_WDAT4, S_WCTRL,
        S_WLOAD, S_CLRLOAD, S_WAIT, S_RD7, S_RD6, S_RCAP, S_OUT
    } state_t;

    typedef struct packed {
        logic        cs_n;
        logic        wr_n;
        logic        rd_n;
        logic [3:0]  addr;
        logic [31:0] wdat;
    } bus_t;

    localparam bus_t BUS_IDLE = '{1'b1, 1'b1, 1'b1, 4'd0, 32'd0};

    state_t      state_reg;
    bus_t        bus_reg;
    logic [79:0] key_reg;
    logic [63:0] data_reg;
    logic        dec_reg;
    logic [79:0] cache_key_reg;
    logic        cache_dec_reg;
    logic        cache_valid_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] result_hi_reg;
    logic [63:0] odata_reg;
    logic        ready_reg;
    logic        valid_reg;
    logic        key_hit;

    // Bus values for the state being entered, so every strobe comes straight off a flop.
    function automatic bus_t bus_decode(input state_t s, input logic [79:0] k,
                                        input logic [63:0] d, input logic dec);
        bus_t b;
        b = BUS_IDLE;
        case (s)
            S_WKEY3:   b = '{1'b0, 1'b0, 1'b1, 4'd3, k[79:48]};
            S_WKEY2:   b = '{1'b0, 1'b0, 1'b1, 4'd2, k[47:16]};
            S_WKEY1:   b = '{1'b0, 1'b0, 1'b1, 4'd1, {16'h0, k[15:0]}};
            S_WDAT5:   b = '{1'b0, 1'b0, 1'b1, 4'd5, d[63:32]};
            S_WDAT4:   b = '{1'b0, 1'b0, 1'b1, 4'd4, d[31:0]};
            S_WCTRL:   b = '{1'b0, 1'b0, 1'b1, 4'd8, {31'h0, dec}};
            S_WLOAD:   b = '{1'b0, 1'b0, 1'b1, 4'd0, 32'h1};
            S_CLRLOAD: b = '{1'b0, 1'b1, 1'b0, 4'd0, 32'h0};
            S_RD7:     b = '{1'b0, 1'b1, 1'b0, 4'd7, 32'h0};
            S_RD6:     b = '{1'b0, 1'b1, 1'b0, 4'd6, 32'h0};
            default:   b = BUS_IDLE;
        endcase
        return b;
    endfunction

    assign key_hit = cache_valid_reg && (iKey == cache_key_reg) && (iDecrypt == cache_dec_reg);

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_reg       <= S_IDLE;
            bus_reg         <= BUS_IDLE;
            key_reg         <= '0;
            data_reg        <= '0;
            dec_reg         <= 1'b0;
            cache_key_reg   <= '0;
            cache_dec_reg   <= 1'b0;
            cache_valid_reg <= 1'b0;
            cnt_reg         <= '0;
            result_hi_reg   <= '0;
            odata_reg       <= '0;
            ready_reg       <= 1'b1;
            valid_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (iValid) begin
                        key_reg   <= iKey;
                        data_reg  <= iData;
                        dec_reg   <= iDecrypt;
                        ready_reg <= 1'b0;
                        if (key_hit) begin
                            state_reg <= S_WDAT5;
                            bus_reg   <= bus_decode(S_WDAT5, iKey, iData, iDecrypt);
                        end else begin
                            state_reg       <= S_WKEY3;
                            bus_reg         <= bus_decode(S_WKEY3, iKey, iData, iDecrypt);
                            cache_key_reg   <= iKey;
                            cache_dec_reg   <= iDecrypt;
                            cache_valid_reg <= 1'b1;
                        end
                    end
                end
                S_WKEY3: begin
                    state_reg <= S_WKEY2;
                    bus_reg   <= bus_decode(S_WKEY2, key_reg, data_reg, dec_reg);
                end
                S_WKEY2: begin
                    state_reg <= S_WKEY1;
                    bus_reg   <= bus_decode(S_WKEY1, key_reg, data_reg, dec_reg);
                end
                S_WKEY1: begin
                    state_reg <= S_WDAT5;
                    bus_reg   <= bus_decode(S_WDAT5, key_reg, data_reg, dec_reg);
                end
                S_WDAT5: begin
                    state_reg <= S_WDAT4;
                    bus_reg   <= bus_decode(S_WDAT4, key_reg, data_reg, dec_reg);
                end
                S_WDAT4: begin
                    state_reg <= S_WCTRL;
                    bus_reg   <= bus_decode(S_WCTRL, key_reg, data_reg, dec_reg);
                end
                S_WCTRL: begin
                    state_reg <= S_WLOAD;
                    bus_reg   <= bus_decode(S_WLOAD, key_reg, data_reg, dec_reg);
                end
                S_WLOAD: begin
                    state_reg <= S_CLRLOAD;
                    bus_reg   <= bus_decode(S_CLRLOAD, key_reg, data_reg, dec_reg);
                end
                S_CLRLOAD: begin
                    state_reg <= S_WAIT;
                    bus_reg   <= BUS_IDLE;
                    cnt_reg   <= 8'(WAIT_CYCLES - 1);
                end
                S_WAIT: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= S_RD7;
                        bus_reg   <= bus_decode(S_RD7, key_reg, data_reg, dec_reg);
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                S_RD7: begin
                    state_reg <= S_RD6;
                    bus_reg   <= bus_decode(S_RD6, key_reg, data_reg, dec_reg);
                end
                // Read data trails its strobe by one cycle, so RD6 captures the addr-7 word.
                S_RD6: begin
                    state_reg     <= S_RCAP;
                    bus_reg       <= BUS_IDLE;
                    result_hi_reg <= iRdat;
                end
                S_RCAP: begin
                    state_reg <= S_OUT;
                    odata_reg <= {result_hi_reg, iRdat};
                    valid_reg <= 1'b1;
                end
                S_OUT: begin
                    if (iReady) begin
                        state_reg <= S_IDLE;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    bus_reg   <= BUS_IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign oReady        = ready_reg;
    assign oValid        = valid_reg;
    assign oData         = odata_reg;
    assign oChipselect_n = bus_reg.cs_n;
    assign oWrite_n      = bus_reg.wr_n;
    assign oRead_n       = bus_reg.rd_n;
    assign oAddress      = bus_reg.addr;
    assign oWdat         = bus_reg.wdat;

endmodule

// File: tb/tb_present_bus_sequencer.sv
// Bench for present_bus_sequencer: a PRESENT-80 wrapper model answers the bus,
// and results, latencies and bus traffic are checked against bench-side expectations.
module tb_present_bus_sequencer;
    localparam int W = 80;

    logic        clk = 1'b0;
    logic        iReset, iValid, iReady, iDecrypt;
    logic [63:0] iData;
    logic [79:0] iKey;
    logic [31:0] iRdat;
    logic        oReady, oValid, oChipselect_n, oWrite_n, oRead_n;
    logic [63:0] oData;
    logic [3:0]  oAddress;
    logic [31:0] oWdat;

    int errors = 0;
    int checks = 0;

    present_bus_sequencer #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .iReset(iReset), .iValid(iValid), .oReady(oReady),
        .iData(iData), .iKey(iKey), .iDecrypt(iDecrypt), .oValid(oValid),
        .iReady(iReady), .oData(oData), .oChipselect_n(oChipselect_n),
        .oWrite_n(oWrite_n), .oRead_n(oRead_n), .oAddress(oAddress),
        .oWdat(oWdat), .iRdat(iRdat)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] isbox(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) if (sbox(4'(v)) == x) r = 4'(v);
        return r;
    endfunction

    function automatic int pidx(input int i);
        return (i == 63) ? 63 : (i * 16) % 63;
    endfunction

    // Reference PRESENT-80 block cipher.
    function automatic logic [63:0] present(input logic [79:0] key, input logic [63:0] blk, input logic dec);
        logic [63:0] rk [1:32];
        logic [79:0] k;
        logic [63:0] s, t;
        k = key;
        for (int r = 1; r <= 32; r++) begin
            rk[r]     = k[79:16];
            k         = {k[18:0], k[79:19]};
            k[79:76]  = sbox(k[79:76]);
            k[19:15]  = k[19:15] ^ 5'(r);
        end
        t = '0;
        if (!dec) begin
            s = blk;
            for (int r = 1; r <= 31; r++) begin
                s = s ^ rk[r];
                for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
                for (int i = 0; i < 64; i++) t[pidx(i)] = s[i];
                s = t;
            end
            s = s ^ rk[32];
        end else begin
            s = blk ^ rk[32];
            for (int r = 31; r >= 1; r--) begin
                for (int i = 0; i < 64; i++) t[i] = s[pidx(i)];
                s = t;
                for (int n = 0; n < 16; n++) s[4*n +: 4] = isbox(s[4*n +: 4]);
                s = s ^ rk[r];
            end
        end
        return s;
    endfunction

    // Wrapper model: register file, one-shot load, result latched at load.
    logic [79:0] w_key;
    logic [63:0] w_dat, w_res;
    logic        w_dec, w_load;
    always @(posedge clk or posedge iReset) begin
        if (iReset) begin
            w_key <= '0; w_dat <= '0; w_dec <= 1'b0; w_load <= 1'b0; w_res <= '0; iRdat <= '0;
        end else begin
            iRdat <= $urandom;
            if (!oChipselect_n && !oWrite_n) begin
                case (oAddress)
                    4'd3: w_key[79:48] <= oWdat;
                    4'd2: w_key[47:16] <= oWdat;
                    4'd1: w_key[15:0]  <= oWdat[15:0];
                    4'd5: w_dat[63:32] <= oWdat;
                    4'd4: w_dat[31:0]  <= oWdat;
                    4'd8: w_dec        <= oWdat[0];
                    4'd0: if (oWdat[0]) begin
                        w_load <= 1'b1;
                        w_res  <= present(w_key, w_dat, w_dec);
                    end
                    default: ;
                endcase
            end
            if (!oChipselect_n && !oRead_n) begin
                case (oAddress)
                    4'd0: begin iRdat <= {31'h0, w_load}; w_load <= 1'b0; end
                    4'd7: iRdat <= w_res[63:32];
                    4'd6: iRdat <= w_res[31:0];
                    default: iRdat <= 32'h0;
                endcase
            end
        end
    end

    // Bus traffic log, never cleared; each operation remembers where its slice starts.
    int          wr_n = 0, rd_n = 0, load_cyc = 0;
    logic [3:0]  wr_a [0:1023];
    logic [31:0] wr_d [0:1023];
    logic [3:0]  rd_a [0:1023];
    always @(posedge clk) begin
        if (!oChipselect_n && !oWrite_n) begin
            wr_a[wr_n] <= oAddress; wr_d[wr_n] <= oWdat; wr_n <= wr_n + 1;
        end
        if (!oChipselect_n && !oRead_n) begin
            rd_a[rd_n] <= oAddress; rd_n <= rd_n + 1;
        end
        if (w_load) load_cyc <= load_cyc + 1;
    end

    logic [79:0] last_key, cur_k;
    logic        last_dec, cur_dec;
    bit          last_valid = 0, cur_miss;
    logic [63:0] cur_d;
    int          wr_base, rd_base, ld_base;

    task automatic note_accept(input logic [79:0] k, input logic [63:0] d, input logic dec);
        cur_k = k; cur_d = d; cur_dec = dec;
        cur_miss = !(last_valid && k == last_key && dec == last_dec);
        if (cur_miss) begin last_key = k; last_dec = dec; last_valid = 1; end
        wr_base = wr_n; rd_base = rd_n; ld_base = load_cyc;
    endtask

    task automatic scramble();
        iKey = {16'($urandom), $urandom, $urandom};
        iData = {$urandom, $urandom};
        iDecrypt = 1'($urandom);
    endtask

    task automatic issue(input logic [79:0] k, input logic [63:0] d, input logic dec);
        @(negedge clk);
        checks++;
        if (oReady !== 1'b1) begin errors++; $display("FAIL issue_ready: oReady=%b required 1", oReady); end
        iKey = k; iData = d; iDecrypt = dec; iValid = 1'b1;
        @(posedge clk);
        #1;
        note_accept(k, d, dec);
        iValid = 1'b0;
        scramble();
    endtask

    task automatic wait_result(input logic [63:0] exp);
        int cyc, want, n, ok;
        logic [35:0] expq[$];
        cyc = 0;
        want = cur_miss ? 12 + W : 9 + W;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (oValid === 1'b1 || cyc > 1000) break;
        end
        checks++;
        if (cyc != want) begin errors++; $display("FAIL latency: oValid in cycle %0d required %0d", cyc, want); end
        checks++;
        if (oData !== exp) begin errors++; $display("FAIL data: oData=%h required %h", oData, exp); end
        if (cur_miss) begin
            expq.push_back({4'd3, cur_k[79:48]});
            expq.push_back({4'd2, cur_k[47:16]});
            expq.push_back({4'd1, 16'h0, cur_k[15:0]});
        end
        expq.push_back({4'd5, cur_d[63:32]});
        expq.push_back({4'd4, cur_d[31:0]});
        expq.push_back({4'd8, 31'h0, cur_dec});
        expq.push_back({4'd0, 32'h1});
        n = wr_n - wr_base;
        checks++;
        if (n != expq.size()) begin
            errors++; $display("FAIL write_count: %0d writes required %0d", n, expq.size());
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if ({wr_a[wr_base+i], wr_d[wr_base+i]} !== expq[i]) begin
                    errors++;
                    $display("FAIL write_%0d: addr=%0d wdat=%h required addr=%0d wdat=%h",
                             i, wr_a[wr_base+i], wr_d[wr_base+i], expq[i][35:32], expq[i][31:0]);
                end
            end
        end
        ok = (rd_n - rd_base == 3) && rd_a[rd_base] == 4'd0 && rd_a[rd_base+1] == 4'd7 && rd_a[rd_base+2] == 4'd6;
        checks++;
        if (!ok) begin errors++; $display("FAIL reads: %0d reads starting addr %0d required 3 reads 0,7,6", rd_n - rd_base, rd_a[rd_base]); end
        checks++;
        if (load_cyc - ld_base != 1) begin errors++; $display("FAIL load_pulse: load high %0d cycles required 1", load_cyc - ld_base); end
        $display("op key=%h data=%h dec=%b miss=%0d -> oData=%h latency=%0d", cur_k, cur_d, cur_dec, cur_miss, oData, cyc);
    endtask

    task automatic release_result(input int hold);
        logic [63:0] held;
        held = oData;
        for (int i = 0; i < hold; i++) begin
            iValid = 1'($urandom);
            scramble();
            @(negedge clk);
            checks++;
            if (oValid !== 1'b1 || oReady !== 1'b0 || oData !== held) begin
                errors++;
                $display("FAIL hold: oValid=%b oReady=%b oData=%h required 1 0 %h", oValid, oReady, oData, held);
            end
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge clk);
        #1;
        iReady = 1'b0;
        checks++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            errors++; $display("FAIL release: oValid=%b oReady=%b required 0 1", oValid, oReady);
        end
    endtask

    task automatic check_reset_outputs();
        checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oData !== 64'h0 || oChipselect_n !== 1'b1 ||
            oWrite_n !== 1'b1 || oRead_n !== 1'b1 || oAddress !== 4'h0 || oWdat !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b data=%h cs=%b wr=%b rd=%b addr=%h wdat=%h required 1 0 0 1 1 1 0 0",
                     oReady, oValid, oData, oChipselect_n, oWrite_n, oRead_n, oAddress, oWdat);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        iReset = 1'b0;
    endtask

    task automatic test_encrypt_cold();
        issue(80'h0, 64'h0, 1'b0);
        wait_result(64'h5579C1387B228445);
        release_result(0);
    endtask

    task automatic test_encrypt_hit();
        issue(80'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        wait_result(64'hA112FFC72F68417B);
        release_result(0);
    endtask

    task automatic test_decrypt_direction();
        issue(80'h0, 64'h5579C1387B228445, 1'b1);
        wait_result(64'h0);
        release_result(0);
    endtask

    task automatic test_backpressure();
        logic [79:0] k;
        logic [63:0] d;
        k = {16'($urandom), $urandom, $urandom};
        d = {$urandom, $urandom};
        issue(k, d, 1'b0);
        wait_result(present(k, d, 1'b0));
        release_result(20);
    endtask

    task automatic test_back_to_back();
        logic [79:0] ka, kb;
        logic [63:0] da, db;
        ka = {16'($urandom), $urandom, $urandom};
        da = {$urandom, $urandom};
        kb = ka;
        db = {$urandom, $urandom};
        issue(ka, da, 1'b1);
        wait_result(present(ka, da, 1'b1));
        iReady = 1'b1; iValid = 1'b1; iKey = kb; iData = db; iDecrypt = 1'b1;
        @(posedge clk);
        #1;
        iReady = 1'b0;
        checks++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            errors++; $display("FAIL b2b_no_accept_in_out: oValid=%b oReady=%b required 0 1", oValid, oReady);
        end
        @(posedge clk);
        #1;
        note_accept(kb, db, 1'b1);
        iValid = 1'b0;
        scramble();
        wait_result(present(kb, db, 1'b1));
        release_result(0);
    endtask

    task automatic test_random();
        logic [79:0] pool [0:1];
        logic [79:0] k;
        logic [63:0] d;
        logic        dec;
        pool[0] = {16'($urandom), $urandom, $urandom};
        pool[1] = {16'($urandom), $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            k = pool[$urandom_range(0, 1)];
            d = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 3) == 0);
            issue(k, d, dec);
            wait_result(present(k, d, dec));
            release_result($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_wait();
        logic [79:0] k;
        logic [63:0] d;
        k = {16'($urandom), $urandom, $urandom} | 80'h1;
        d = {$urandom, $urandom};
        issue(k, d, 1'b0);
        repeat (30) @(negedge clk);
        iReset = 1'b1;
        #1;
        check_reset_outputs();
        last_valid = 0;
        @(negedge clk);
        iReset = 1'b0;
        issue(k, d, 1'b0);
        checks++;
        if (!cur_miss) begin errors++; $display("FAIL reset_cache_tracker: miss=%0d required 1", cur_miss); end
        wait_result(present(k, d, 1'b0));
        release_result(0);
    endtask

    initial begin
        iReset = 1'b1; iValid = 1'b0; iReady = 1'b0;
        iKey = '0; iData = '0; iDecrypt = 1'b0;
        test_reset();
        test_encrypt_cold();
        test_encrypt_hit();
        test_decrypt_direction();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
